// File: rtl/sobel_filter_if.sv
// FIFO-side handshake bundle for the Sobel stage: grayscale FIFO read port and sobel FIFO write port.
// The filter uses the master view; the surrounding FIFOs (or a bench) use the slave view.
interface sobel_filter_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] in_dout;
    logic              in_empty;
    logic              in_rd_en;
    logic [DWIDTH-1:0] out_din;
    logic              out_full;
    logic              out_wr_en;

    modport master (
        input  in_dout, in_empty, out_full,
        output in_rd_en, out_din, out_wr_en
    );

    modport slave (
        output in_dout, in_empty, out_full,
        input  in_rd_en, out_din, out_wr_en
    );
endinterface

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge stage: raster-order luma in, raster-order |Gx|+|Gy| out, borders forced to 0.
// Define SOBEL_THRESHOLD_EN to binarise interior pixels against THRESHOLD instead of saturating.
module sobel_filter #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int DWIDTH     = 8,
    parameter int THRESHOLD  = 128
) (
    input  logic          clock,
    input  logic          reset,
    sobel_filter_if.master bus
);
    localparam int WIN_LEN = 2 * IMG_WIDTH + 2;
    localparam int NPIX    = IMG_WIDTH * IMG_HEIGHT;
    localparam int PIX_W   = $clog2(NPIX + 1);
    localparam int COL_W   = $clog2(IMG_WIDTH);
    localparam int ROW_W   = $clog2(IMG_HEIGHT);
    localparam int SUM_W   = DWIDTH + 2;
    localparam int MAG_W   = DWIDTH + 3;
    localparam logic [DWIDTH-1:0] PIX_MAX = '1;
`ifdef SOBEL_THRESHOLD_EN
    localparam bit THRESH_EN = 1'b1;
`else
    localparam bit THRESH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t            state, next_state;
    logic [DWIDTH-1:0] win [WIN_LEN];
    logic [PIX_W-1:0]  pop_cnt;
    logic [ROW_W-1:0]  out_row;
    logic [COL_W-1:0]  out_col;
    logic [DWIDTH-1:0] out_reg;
    logic              out_vld;
    logic              advance, pop, load, load_zero, frame_done;
    logic              last_col, last_row, border;
    logic [DWIDTH-1:0] pa, pb, pc, pd, pf, pg, ph, pi;
    logic [SUM_W-1:0]  gx_pos, gx_neg, gy_pos, gy_neg, gx_abs, gy_abs;
    logic [MAG_W-1:0]  mag;
    logic [DWIDTH-1:0] interior;

    // win[k] holds pixel n-1-k before pixel n shifts in, so the incoming pixel is the bottom-right tap
    assign pa = win[2*IMG_WIDTH+1];
    assign pb = win[2*IMG_WIDTH];
    assign pc = win[2*IMG_WIDTH-1];
    assign pd = win[IMG_WIDTH+1];
    assign pf = win[IMG_WIDTH-1];
    assign pg = win[1];
    assign ph = win[0];
    assign pi = bus.in_dout;

    assign gx_pos = SUM_W'(pc) + (SUM_W'(pf) << 1) + SUM_W'(pi);
    assign gx_neg = SUM_W'(pa) + (SUM_W'(pd) << 1) + SUM_W'(pg);
    assign gy_pos = SUM_W'(pg) + (SUM_W'(ph) << 1) + SUM_W'(pi);
    assign gy_neg = SUM_W'(pa) + (SUM_W'(pb) << 1) + SUM_W'(pc);
    assign gx_abs = (gx_pos >= gx_neg) ? gx_pos - gx_neg : gx_neg - gx_pos;
    assign gy_abs = (gy_pos >= gy_neg) ? gy_pos - gy_neg : gy_neg - gy_pos;
    assign mag    = MAG_W'(gx_abs) + MAG_W'(gy_abs);

    assign interior = THRESH_EN ? ((mag >= MAG_W'(THRESHOLD)) ? PIX_MAX : '0)
                                : ((mag > MAG_W'(PIX_MAX)) ? PIX_MAX : mag[DWIDTH-1:0]);

    assign last_col = (out_col == COL_W'(IMG_WIDTH - 1));
    assign last_row = (out_row == ROW_W'(IMG_HEIGHT - 1));
    assign border   = (out_row == '0) | last_row | (out_col == '0) | last_col;

    assign advance       = ~out_vld | ~bus.out_full;
    assign bus.in_rd_en  = pop;
    assign bus.out_wr_en = out_vld & ~bus.out_full & ~reset;
    assign bus.out_din   = out_reg;

    always_ff @(posedge clock) begin
        if (reset) state <= FILL;
        else       state <= next_state;
    end

    // FILL primes the window, RUN pairs each pop with one result, FLUSH emits the trailing border pixels
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        load       = 1'b0;
        load_zero  = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            FILL: begin
                pop = ~bus.in_empty;
                if (pop && pop_cnt == PIX_W'(IMG_WIDTH)) next_state = RUN;
            end
            RUN: begin
                pop  = ~bus.in_empty & advance;
                load = pop;
                if (pop && pop_cnt == PIX_W'(NPIX - 1)) next_state = FLUSH;
            end
            FLUSH: begin
                load      = advance;
                load_zero = 1'b1;
                if (advance && last_row && last_col) begin
                    next_state = FILL;
                    frame_done = 1'b1;
                end
            end
            default: next_state = FILL;
        endcase
        if (reset) pop = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < WIN_LEN; k++) win[k] <= '0;
            pop_cnt <= '0;
            out_row <= '0;
            out_col <= '0;
            out_reg <= '0;
            out_vld <= 1'b0;
        end else begin
            if (pop) begin
                win[0] <= bus.in_dout;
                for (int k = 1; k < WIN_LEN; k++) win[k] <= win[k-1];
                pop_cnt <= pop_cnt + PIX_W'(1);
            end
            if (frame_done) pop_cnt <= '0;
            // out_row/out_col follow the pixel whose result is being loaded
            if (load) begin
                out_reg <= (load_zero | border) ? '0 : interior;
                out_vld <= 1'b1;
                if (last_col) begin
                    out_col <= '0;
                    out_row <= last_row ? '0 : out_row + ROW_W'(1);
                end else begin
                    out_col <= out_col + COL_W'(1);
                end
            end else if (advance) begin
                out_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sobel_filter.sv
// Self-checking bench for sobel_filter on an 8x6 image: FIFO models, random stalls and a 2-D Sobel reference.
// Honours SOBEL_THRESHOLD_EN the same way the design does.
module tb_sobel_filter;
    localparam int W   = 8;
    localparam int H   = 6;
    localparam int DW  = 8;
    localparam int THR = 128;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sobel_filter_if #(.DWIDTH(DW)) bus ();

    sobel_filter #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH(DW), .THRESHOLD(THR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int          compared   = 0;
    int          mismatched = 0;
    logic [7:0]  in_q[$];
    int          exp_q[$];
    int          img[H][W];
    int          mode;
    int          pops, writes, cyc, tenth_pop_cyc, first_wr_cyc;

    task automatic check_output(input string tag, input int got, input int want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Reference: direct 2-D Sobel on the stored image
    function automatic int ref_pixel(input int r, input int c);
        int gx, gy, m;
        if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
        gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
        return (m >= THR) ? 255 : 0;
`else
        return (m > 255) ? 255 : m;
`endif
    endfunction

    task automatic apply_stimulus(input int kind, input int val);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0:       img[r][c] = val;
                    1:       img[r][c] = (c < 4) ? 0 : 255;
                    2:       img[r][c] = val * c;
                    3:       img[r][c] = int'($urandom_range(0, 255));
                    default: img[r][c] = int'($urandom_range(0, val));
                endcase
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                in_q.push_back(8'(img[r][c]));
                exp_q.push_back(ref_pixel(r, c));
            end
    endtask

    task automatic step_cycle();
        logic stall_in, stall_out;
        @(negedge clock);
        case (mode)
            1: begin
                stall_in  = ($urandom_range(0, 3) == 0);
                stall_out = ($urandom_range(0, 3) == 0);
            end
            2: begin
                stall_in  = (cyc % 2) == 1;
                stall_out = (cyc >= 15 && cyc < 35);
            end
            default: begin
                stall_in  = 1'b0;
                stall_out = 1'b0;
            end
        endcase
        bus.in_empty = (in_q.size() == 0) || stall_in;
        bus.in_dout  = (in_q.size() != 0) ? in_q[0] : 8'h00;
        bus.out_full = stall_out;
        #4;
        if (bus.in_empty) check_output("rd_while_empty", int'(bus.in_rd_en), 0);
        if (bus.out_full) check_output("wr_while_full", int'(bus.out_wr_en), 0);
        if (bus.in_rd_en && in_q.size() != 0) begin
            void'(in_q.pop_front());
            pops++;
            if (pops == 10) tenth_pop_cyc = cyc;
        end
        if (bus.out_wr_en) begin
            if (writes == 0) first_wr_cyc = cyc;
            if (exp_q.size() != 0)
                check_output($sformatf("pixel%0d", writes), int'(bus.out_din), exp_q.pop_front());
            else
                check_output("extra_write", int'(bus.out_wr_en), 0);
            writes++;
        end
        cyc++;
    endtask

    task automatic start_run(input int m);
        mode          = m;
        pops          = 0;
        writes        = 0;
        cyc           = 0;
        tenth_pop_cyc = -1;
        first_wr_cyc  = -1;
    endtask

    task automatic run_writes(input int n);
        int budget = 0;
        while (writes < n && budget < 3000) begin
            step_cycle();
            budget++;
        end
        check_output("write_count", writes, n);
        repeat (20) step_cycle();
        check_output("final_write_count", writes, n);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            bus.in_empty = 1'b0;
            bus.in_dout  = 8'hAA;
            bus.out_full = 1'b0;
            #4;
            check_output("rst_rd_en", int'(bus.in_rd_en), 0);
            check_output("rst_wr_en", int'(bus.out_wr_en), 0);
            if (i > 0) check_output("rst_out_din", int'(bus.out_din), 0);
        end
        @(negedge clock);
        reset        = 1'b0;
        bus.in_empty = 1'b1;
        in_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int budget;
        reset        = 1'b1;
        bus.in_empty = 1'b1;
        bus.in_dout  = 8'h00;
        bus.out_full = 1'b0;
        apply_reset();

        $display("[TB] uniform 0x80 frame");
        start_run(0);
        apply_stimulus(0, 128);
        run_writes(48);
        check_output("first_write_latency", first_wr_cyc - tenth_pop_cyc, 1);

        $display("[TB] vertical step frame");
        start_run(0);
        apply_stimulus(1, 0);
        run_writes(48);

        $display("[TB] column ramps");
        start_run(0);
        apply_stimulus(2, 10);
        run_writes(48);
        start_run(0);
        apply_stimulus(2, 20);
        run_writes(48);

        $display("[TB] step frame with output stall and toggling input");
        start_run(2);
        apply_stimulus(1, 0);
        run_writes(48);

        $display("[TB] reset mid-frame then step frame");
        start_run(0);
        apply_stimulus(1, 0);
        budget = 0;
        while (pops < 20 && budget < 200) begin
            step_cycle();
            budget++;
        end
        check_output("pops_before_reset", pops, 20);
        apply_reset();
        start_run(0);
        apply_stimulus(1, 0);
        run_writes(48);

        $display("[TB] back-to-back frames");
        start_run(0);
        apply_stimulus(0, 128);
        apply_stimulus(1, 0);
        run_writes(96);

        $display("[TB] random frames with random stalls");
        for (int f = 0; f < 4; f++) begin
            start_run(1);
            apply_stimulus((f % 2 == 0) ? 3 : 4, 60);
            run_writes(48);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
